rsc_dec_sched: RTL and testbench
================================

Name: rsc_dec_sched

Overview:
- Half-iteration scheduler for the duobit RSC turbo decoder.
- Sequences the branch-metric stage: reads the systematic and parity buffers, then drives that stage's valid, even, bitswap and Lextr_clr controls.
- Alternates natural-order (even) and interleaved (odd) half iterations, using an incremental CTC-style permutation address generator, for iNiter iterations.
- Sits between the decoder top-level start/done handshake and the buffer read ports / BMC inputs.

Parameters:
pN_W, 12, duobit address/length width (N <= 2^pN_W-1)
pITER_W, 5, iteration counter width
pRAM_LAT, 1, buffer read latency in cycles; control outputs delayed to match oaddr

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  global clock enable; all state frozen when 0
istart  in  1  start pulse, accepted only in IDLE
iN  in  pN_W  duobit block length, even, >= 8
iP0  in  pN_W  permutation step, 0 < iP0 < iN
iP1, iP2, iP3  in  pN_W each  permutation offsets, each < iN
iNiter  in  pITER_W  full iterations, >= 1
ihalf_done  in  1  MAP engine finished writing extrinsic for the current half
oaddr  out  pN_W  buffer read address (duobit index)
oval  out  1  BMC ival, aligned to read data
oeven  out  1  BMC ieven
obitswap  out  1  BMC ibitswap
oLextr_clr  out  1  BMC iLextr_clr
olast  out  1  last duobit of the half, aligned with oval
oiter  out  pITER_W  current iteration index
obusy  out  1  high from istart acceptance to odone
odone  out  1  one-cycle done pulse

Behaviour:
- Reset: state=IDLE; oaddr=0, oval=0, oeven=0, obitswap=0, oLextr_clr=0, olast=0, oiter=0, obusy=0, odone=0; delay line cleared.
- All registers advance only when iclkena=1. This includes the pRAM_LAT delay line.
- Even half:
  - oaddr = j for j = 0..N-1.
  - oeven=1, obitswap=0.
- Odd half:
  - oaddr = (P0*j + Q[j mod 4] + 1) mod N, with Q = {0, N/2+P1, P2, N/2+P3} mod N.
  - oeven=0.
  - obitswap = (j mod 2 == 0).
- Address arithmetic:
  - acc = P0*j mod N is kept incrementally: acc += P0, subtract N if >= N.
  - Q is latched, reduced mod N, in SETUP.
  - sum = acc + Q + 1 <= 2N-1, one conditional subtract. No multipliers.
- oLextr_clr=1 for every oval of the even half of iteration 0 only.
- State machine:
  - IDLE: obusy=0. On istart go to SETUP, latching iN, iP*, iNiter.
  - SETUP: 1 cycle. Compute Q, clear j, acc, oiter. Go to RUN_E.
  - RUN_E / RUN_O: issue one address per enabled cycle, j=0..N-1. After j=N-1 go to WAIT_E / WAIT_O.
  - WAIT_E: wait for ihalf_done, then go to RUN_O.
  - WAIT_O: wait for ihalf_done. Then if oiter == iNiter-1 go to DONE, else increment oiter and go to RUN_E.
  - DONE: wait until the delay line is empty, pulse odone for 1 cycle, go to IDLE.
- Latency and alignment:
  - oaddr is registered and valid the cycle after the state/counter update.
  - oval/oeven/obitswap/oLextr_clr/olast lag oaddr by exactly pRAM_LAT cycles.
- Boundary cases:
  - istart while busy is ignored.
  - ihalf_done outside WAIT_* is ignored.
  - ihalf_done asserted on the same cycle the half's last address issues is not remembered; it must arrive in WAIT_*.
  - Reset mid-run returns to IDLE immediately and cleanly; no odone.
  - iclkena=0 in any state holds every output stable.

Optional Feature:
RSC_DEC_SCHED_EARLY_STOP_EN
- Defined:
  - Adds input istop (1 bit).
  - istop seen high in WAIT_O together with ihalf_done forces DONE regardless of oiter.
  - oiter keeps the index of the last completed iteration.
- Undefined: no istop port; exactly iNiter iterations always run.

Test Plan:
- Reset, then idle with iclkena=1 -> all outputs 0, obusy=0; istart with ireset_n low is ignored.
- N=48, P0=11, P1=24, P2=0, P3=24, Niter=1, ihalf_done returned 5 cycles after each half -> even half addrs 0..47, oeven=1, oLextr_clr=1; odd half addrs 1,12,23,34,45,... with obitswap 1,0,1,0,1; olast on the 48th oval of each half; odone once after the 2nd ihalf_done.
- Same config with Niter=3 -> 6 halves; oiter steps 0,1,2; oLextr_clr only in the first half; odd-half address sequence identical each iteration and a permutation of 0..47.
- iclkena toggled at random 50% duty during the N=48 run -> same address/control sequence as with constant enable; outputs frozen on disabled cycles.
- ireset_n low during RUN_O of iteration 1 -> next cycle state IDLE, oval=0, obusy=0, no odone; a fresh istart reruns from iteration 0 with oLextr_clr=1.
- With RSC_DEC_SCHED_EARLY_STOP_EN, Niter=4, istop=1 at the first WAIT_O -> odone after 2 halves, oiter=0.

Source files
------------

// File: rtl/rsc_dec_sched.sv
// ---------------------------------------------------------------------------
// rsc_dec_sched -- half-iteration scheduler for the duobit RSC turbo decoder.
//
// The scheduler takes a start pulse from the decoder top level. It then issues
// systematic/parity buffer read addresses and the matching branch-metric
// controls. Each iteration has two halves:
//   - even half: natural order, j = 0..N-1
//   - odd half:  interleaved order, (P0*j + Q[j mod 4] + 1) mod N
// The odd-half address is built incrementally with adders only.
// After each half the scheduler waits for the MAP engine to report
// ihalf_done. After iNiter iterations it pulses odone.
//
// Optional build macro: RSC_DEC_SCHED_EARLY_STOP_EN
//   When defined, an istop input is added. If istop is high together with
//   ihalf_done at the end of an odd half, the block finishes early. oiter then
//   holds the index of the last completed iteration.
//
// Ports:
//   iclk, ireset_n     clock, asynchronous active-low reset
//   iclkena            global clock enable (everything frozen when low)
//   istart             start pulse, accepted only while idle
//   iN                 duobit block length (even, >= 8)
//   iP0..iP3           CTC permutation step and offsets
//   iNiter             number of full iterations (>= 1)
//   ihalf_done         MAP engine finished the current half
//   istop              early-stop request (only with the macro)
//   oaddr              buffer read address
//   oval/oeven/obitswap/oLextr_clr/olast
//                      BMC controls, aligned with the read data
//                      (pRAM_LAT cycles after oaddr; pRAM_LAT must be >= 1)
//   oiter              current iteration index
//   obusy              high from start acceptance through the odone cycle
//   odone              one-cycle completion pulse
// ---------------------------------------------------------------------------
module rsc_dec_sched #(
    parameter int pN_W     = 12,
    parameter int pITER_W  = 5,
    parameter int pRAM_LAT = 1
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic               istart,
    input  logic [pN_W-1:0]    iN,
    input  logic [pN_W-1:0]    iP0,
    input  logic [pN_W-1:0]    iP1,
    input  logic [pN_W-1:0]    iP2,
    input  logic [pN_W-1:0]    iP3,
    input  logic [pITER_W-1:0] iNiter,
    input  logic               ihalf_done,
`ifdef RSC_DEC_SCHED_EARLY_STOP_EN
    input  logic               istop,
`endif
    output logic [pN_W-1:0]    oaddr,
    output logic               oval,
    output logic               oeven,
    output logic               obitswap,
    output logic               oLextr_clr,
    output logic               olast,
    output logic [pITER_W-1:0] oiter,
    output logic               obusy,
    output logic               odone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN_E,
        S_WAIT_E,
        S_RUN_O,
        S_WAIT_O,
        S_DONE
    } state_t;

    // Control word layout: {val, even, bitswap, Lextr_clr, last}
    localparam int CW = 5;

    state_t              state_q;
    logic [pN_W-1:0]     n_q, p0_q, p1_q, p2_q, p3_q;
    logic [pITER_W-1:0]  niter_q;
    logic [pN_W-1:0]     q_q [4];
    logic [pN_W-1:0]     j_q;
    logic [pN_W-1:0]     acc_q;
    logic [pN_W-1:0]     addr_q;
    logic [pITER_W-1:0]  iter_q;
    logic                busy_q;
    logic                done_q;
    // Stage 0 is aligned with addr_q; stage pRAM_LAT drives the outputs.
    logic [CW-1:0]       dly_q [pRAM_LAT+1];

    logic [pN_W-1:0]     acc_d;
    logic [pN_W-1:0]     odd_addr_d;
    logic [pN_W-1:0]     q1_d, q2_d, q3_d;
    logic                last_d;
    logic                dly_empty_d;
    logic                stop_d;
    logic [CW-1:0]       iss_d;

    // Single conditional subtract: valid because every operand sum is < 2N.
    function automatic logic [pN_W-1:0] mod_once(input logic [pN_W:0] v,
                                                 input logic [pN_W-1:0] n);
        logic [pN_W:0] r;
        r = (v >= {1'b0, n}) ? (v - {1'b0, n}) : v;
        return r[pN_W-1:0];
    endfunction

`ifdef RSC_DEC_SCHED_EARLY_STOP_EN
    assign stop_d = istop;
`else
    assign stop_d = 1'b0;
`endif

    always_comb begin
        // acc tracks P0*j mod N for the address currently being issued.
        acc_d      = mod_once({1'b0, acc_q} + {1'b0, p0_q}, n_q);
        odd_addr_d = mod_once({1'b0, acc_q} + {1'b0, q_q[j_q[1:0]]}
                              + {{pN_W{1'b0}}, 1'b1}, n_q);
        q1_d       = mod_once({2'b00, n_q[pN_W-1:1]} + {1'b0, p1_q}, n_q);
        q2_d       = mod_once({1'b0, p2_q}, n_q);
        q3_d       = mod_once({2'b00, n_q[pN_W-1:1]} + {1'b0, p3_q}, n_q);
        last_d     = (j_q == n_q - 1'b1);
    end

    always_comb begin
        iss_d = '0;
        case (state_q)
            S_RUN_E: iss_d = {1'b1, 1'b1, 1'b0, (iter_q == '0), last_d};
            S_RUN_O: iss_d = {1'b1, 1'b0, ~j_q[0], 1'b0, last_d};
            default: iss_d = '0;
        endcase
    end

    always_comb begin
        dly_empty_d = 1'b1;
        for (int k = 0; k <= pRAM_LAT; k++) begin
            if (dly_q[k][CW-1]) begin
                dly_empty_d = 1'b0;
            end
        end
    end

    // Control delay line matching the buffer read latency.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int k = 0; k <= pRAM_LAT; k++) begin
                dly_q[k] <= '0;
            end
        end else if (iclkena) begin
            dly_q[0] <= iss_d;
            for (int k = 1; k <= pRAM_LAT; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    // Main state machine.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            niter_q <= '0;
            for (int k = 0; k < 4; k++) begin
                q_q[k] <= '0;
            end
            j_q     <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (iclkena) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (istart) begin
                        n_q     <= iN;
                        p0_q    <= iP0;
                        p1_q    <= iP1;
                        p2_q    <= iP2;
                        p3_q    <= iP3;
                        niter_q <= iNiter;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    q_q[0]  <= '0;
                    q_q[1]  <= q1_d;
                    q_q[2]  <= q2_d;
                    q_q[3]  <= q3_d;
                    j_q     <= '0;
                    acc_q   <= '0;
                    iter_q  <= '0;
                    state_q <= S_RUN_E;
                end
                S_RUN_E: begin
                    addr_q <= j_q;
                    if (last_d) begin
                        j_q     <= '0;
                        state_q <= S_WAIT_E;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_WAIT_E: begin
                    if (ihalf_done) begin
                        acc_q   <= '0;
                        state_q <= S_RUN_O;
                    end
                end
                S_RUN_O: begin
                    addr_q <= odd_addr_d;
                    if (last_d) begin
                        j_q     <= '0;
                        acc_q   <= '0;
                        state_q <= S_WAIT_O;
                    end else begin
                        j_q   <= j_q + 1'b1;
                        acc_q <= acc_d;
                    end
                end
                S_WAIT_O: begin
                    if (ihalf_done) begin
                        if ((iter_q == niter_q - 1'b1) || stop_d) begin
                            state_q <= S_DONE;
                        end else begin
                            iter_q  <= iter_q + 1'b1;
                            state_q <= S_RUN_E;
                        end
                    end
                end
                S_DONE: begin
                    // Let the last controls drain before reporting completion.
                    if (dly_empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oaddr = addr_q;
    assign {oval, oeven, obitswap, oLextr_clr, olast} = dly_q[pRAM_LAT];
    assign oiter = iter_q;
    assign obusy = busy_q;
    assign odone = done_q;

endmodule

// File: tb/tb_rsc_dec_sched.sv
// ---------------------------------------------------------------------------
// tb_rsc_dec_sched -- directed self-checking bench for rsc_dec_sched.
// A monitor records every oval beat as {addr, even, bitswap, clr, last, iter}.
// It also checks that the outputs hold on disabled cycles. Each run is
// compared against a reference sequence. That sequence is built from the
// closed-form permutation (P0*j + Q[j mod 4] + 1) mod N.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rsc_dec_sched;

    localparam int NW = 12;
    localparam int IW = 5;

    logic          iclk = 1'b0;
    logic          ireset_n = 1'b0;
    logic          iclkena = 1'b1;
    logic          istart = 1'b0;
    logic [NW-1:0] iN = '0, iP0 = '0, iP1 = '0, iP2 = '0, iP3 = '0;
    logic [IW-1:0] iNiter = '0;
    logic          ihalf_done = 1'b0;
`ifdef RSC_DEC_SCHED_EARLY_STOP_EN
    logic          istop = 1'b0;
`endif
    logic [NW-1:0] oaddr;
    logic          oval, oeven, obitswap, oLextr_clr, olast, obusy, odone;
    logic [IW-1:0] oiter;

    rsc_dec_sched #(.pN_W(NW), .pITER_W(IW), .pRAM_LAT(1)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .istart(istart),
        .iN(iN), .iP0(iP0), .iP1(iP1), .iP2(iP2), .iP3(iP3),
        .iNiter(iNiter), .ihalf_done(ihalf_done),
`ifdef RSC_DEC_SCHED_EARLY_STOP_EN
        .istop(istop),
`endif
        .oaddr(oaddr), .oval(oval), .oeven(oeven), .obitswap(obitswap),
        .oLextr_clr(oLextr_clr), .olast(olast), .oiter(oiter),
        .obusy(obusy), .odone(odone)
    );

    always #5 iclk = ~iclk;

    int n_assert = 0;
    int n_fail   = 0;
    int half_cnt = 0;
    int done_cnt = 0;

    logic [NW+IW+3:0] rec_q[$];
    logic [NW-1:0]    addr_hist = '0;
    logic             en_last = 1'b1;
    logic [NW+IW+6:0] snap = '0;
    logic [NW+IW+6:0] cur_outs;

    assign cur_outs = {oaddr, oval, oeven, obitswap, oLextr_clr, olast, oiter, obusy, odone};

    always @(posedge iclk) en_last <= iclkena;

    // Monitor: record beats on enabled edges, check hold on disabled ones.
    always @(negedge iclk) begin
        if (en_last) begin
            if (oval) begin
                rec_q.push_back({addr_hist, oeven, obitswap, oLextr_clr, olast, oiter});
                if (olast) half_cnt++;
            end
            if (odone) done_cnt++;
            addr_hist = oaddr;
        end else begin
            n_assert++;
            assert (cur_outs === snap) else begin
                n_fail++;
                $error("FAIL hold got=%h exp=%h", cur_outs, snap);
            end
        end
        snap = cur_outs;
    end

    task automatic ticks(input int k);
        repeat (k) begin
            @(posedge iclk);
            #1;
        end
    endtask

    // Start one block and answer each finished half with ihalf_done about
    // five enabled cycles later. Stops on odone, budget, or abort record count.
    task automatic run_block(input int n, input int p0, input int p1, input int p2,
                             input int p3, input int niter, input bit rnd,
                             input bit spur, input int abort_at, input int budget);
        int  cd, seen, d0, c;
        bit  edge_en;
        iN = NW'(n); iP0 = NW'(p0); iP1 = NW'(p1); iP2 = NW'(p2); iP3 = NW'(p3);
        iNiter = IW'(niter);
        iclkena = 1'b1;
        istart = 1'b1;
        cd = -1; seen = half_cnt; d0 = done_cnt; c = 0;
        while (done_cnt == d0 && c < budget && !(abort_at > 0 && rec_q.size() >= abort_at)) begin
            @(posedge iclk);
            edge_en = iclkena;
            #1;
            if (edge_en) begin
                istart = 1'b0;
                if (ihalf_done) begin
                    ihalf_done = 1'b0;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        ihalf_done = 1'b1;
                        cd = -1;
                    end
                end
            end
            if (half_cnt != seen) begin
                seen = half_cnt;
                cd = 5;
            end
            if (spur && c == 10) ihalf_done = 1'b1;   // lands in RUN_E
            if (spur && c == 20) istart = 1'b1;       // start while busy
            if (c == 3) begin
                n_assert++;
                assert (obusy === 1'b1) else begin
                    n_fail++;
                    $error("FAIL busy_run got=%b exp=1", obusy);
                end
            end
            iclkena = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            c++;
        end
        iclkena = 1'b1;
        ihalf_done = 1'b0;
        istart = 1'b0;
        if (abort_at == 0) begin
            n_assert++;
            assert (done_cnt === d0 + 1) else begin
                n_fail++;
                $error("FAIL done_timeout got=%0d exp=%0d", done_cnt, d0 + 1);
            end
        end
    endtask

    task automatic check_seq(input string tag, input int n, input int p0, input int p1,
                             input int p2, input int p3, input int halves, input bit perm);
        int q[4];
        int a, idx;
        logic [NW+IW+3:0] exp_v;
        logic [4095:0] seen_map;
        q[0] = 0; q[1] = (n/2 + p1) % n; q[2] = p2 % n; q[3] = (n/2 + p3) % n;
        seen_map = '0;
        n_assert++;
        assert (rec_q.size() === n * halves) else begin
            n_fail++;
            $error("FAIL %s_len got=%0d exp=%0d", tag, rec_q.size(), n * halves);
        end
        idx = 0;
        for (int h = 0; h < halves; h++) begin
            for (int j = 0; j < n; j++) begin
                if (h % 2 == 0) a = j;
                else a = (p0 * j + q[j % 4] + 1) % n;
                exp_v = {NW'(a), (h % 2 == 0), (h % 2 == 1) && (j % 2 == 0),
                         (h == 0), (j == n - 1), IW'(h / 2)};
                if (idx < rec_q.size()) begin
                    if (h == 1) seen_map[rec_q[idx][NW+IW+3:IW+4]] = 1'b1;
                    n_assert++;
                    assert (rec_q[idx] === exp_v) else begin
                        n_fail++;
                        $error("FAIL %s_beat h=%0d j=%0d got=%h exp=%h", tag, h, j, rec_q[idx], exp_v);
                    end
                end
                idx++;
            end
        end
        if (perm) begin
            n_assert++;
            assert ($countones(seen_map) === n) else begin
                n_fail++;
                $error("FAIL %s_perm got=%0d exp=%0d", tag, $countones(seen_map), n);
            end
        end
        rec_q.delete();
    endtask

    task automatic check_idle(input string tag, input logic [IW-1:0] it);
        ticks(4);
        n_assert++;
        assert ({oval, obusy, odone, oiter} === {1'b0, 1'b0, 1'b0, it}) else begin
            n_fail++;
            $error("FAIL %s_idle got=%b%b%b/%0d exp=000/%0d", tag, oval, obusy, odone, oiter, it);
        end
    endtask

    int d_before;

    initial begin
        // Reset with istart held high: must be ignored.
        ireset_n = 1'b0; istart = 1'b1; iclkena = 1'b1;
        ticks(3);
        n_assert++;
        assert (cur_outs === '0) else begin
            n_fail++;
            $error("FAIL reset got=%h exp=0", cur_outs);
        end
        istart = 1'b0;
        ireset_n = 1'b1;
        ticks(3);
        n_assert++;
        assert (cur_outs === '0) else begin
            n_fail++;
            $error("FAIL idle_after_reset got=%h exp=0", cur_outs);
        end

        // One iteration, with a spurious ihalf_done and istart while running.
        run_block(48, 11, 24, 0, 24, 1, 1'b0, 1'b1, 0, 1000);
        check_seq("n48_it1", 48, 11, 24, 0, 24, 2, 1'b1);
        check_idle("n48_it1", 5'd0);

        // Three iterations.
        run_block(48, 11, 24, 0, 24, 3, 1'b0, 1'b0, 0, 2000);
        check_seq("n48_it3", 48, 11, 24, 0, 24, 6, 1'b1);
        check_idle("n48_it3", 5'd2);

        // Random clock enable.
        run_block(48, 11, 24, 0, 24, 1, 1'b1, 1'b1, 0, 3000);
        check_seq("n48_rnd", 48, 11, 24, 0, 24, 2, 1'b1);
        check_idle("n48_rnd", 5'd0);

        // Non-zero Q offsets.
        run_block(48, 7, 5, 13, 30, 1, 1'b0, 1'b0, 0, 1000);
        check_seq("n48_q", 48, 7, 5, 13, 30, 2, 1'b0);
        check_idle("n48_q", 5'd0);

        // Minimum block length.
        run_block(8, 3, 1, 2, 3, 2, 1'b0, 1'b0, 0, 500);
        check_seq("n8", 8, 3, 1, 2, 3, 4, 1'b0);
        check_idle("n8", 5'd1);

        // Reset during the odd half of iteration 1.
        d_before = done_cnt;
        run_block(48, 11, 24, 0, 24, 3, 1'b0, 1'b0, 3 * 48 + 10, 2000);
        ireset_n = 1'b0;
        #1;
        n_assert++;
        assert (cur_outs === '0) else begin
            n_fail++;
            $error("FAIL midrun_reset got=%h exp=0", cur_outs);
        end
        ticks(2);
        ireset_n = 1'b1;
        ticks(3);
        n_assert++;
        assert (done_cnt === d_before) else begin
            n_fail++;
            $error("FAIL midrun_nodone got=%0d exp=%0d", done_cnt, d_before);
        end
        rec_q.delete();
        run_block(48, 11, 24, 0, 24, 1, 1'b0, 1'b0, 0, 1000);
        check_seq("rerun", 48, 11, 24, 0, 24, 2, 1'b1);
        check_idle("rerun", 5'd0);

`ifdef RSC_DEC_SCHED_EARLY_STOP_EN
        istop = 1'b1;
        run_block(48, 11, 24, 0, 24, 4, 1'b0, 1'b0, 0, 2000);
        check_seq("estop", 48, 11, 24, 0, 24, 2, 1'b1);
        check_idle("estop", 5'd0);
        istop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
